sram_scan_ctrl: RTL
===================

# sram_scan_ctrl

Parametrised scan-chain SRAM test controller for the user project area. It generalises the GPIO-driven SRAM scan interface in four ways: configurable address, data, mask and select widths; an on-chip launch/capture state machine; auto-incrementing burst access; and optional read-data compare. It sits between GPIO pads (scan in/out, scan enable, launch) and a bank of dual-port/single-port OpenRAM macros, which are selected externally by `sel_o`.

## Interface
Parameters:
- `ADDR_W`, 16, address width per port
- `DATA_W`, 32, data width per port
- `MASK_W`, 4, write-mask width per port
- `SEL_W`, 4, memory-select field width
- `BURST_W`, 4, burst-count field width
- `READ_LAT`, 1, cycles from `csbN_o` low to valid `doutN_i`

Ports:
- `wb_clk_i`  in  1  sole clock
- `wb_rst_i`  in  1  reset, synchronous, active-high
- `scan_en_i`  in  1  shift chain one bit per clock
- `scan_in_i`  in  1  serial in, MSB first
- `scan_out_o`  out  1  serial out = chain MSB
- `launch_i`  in  1  rising edge starts an access sequence
- `busy_o`  out  1  sequence in progress
- `done_o`  out  1  one-cycle pulse at sequence end
- `err_o`  out  1  sticky compare mismatch
- `sel_o`  out  SEL_W  memory select
- `csb0_o`, `web0_o`  out  1  port-0 chip select / write enable, active low
- `wmask0_o`  out  MASK_W;  `addr0_o`  out  ADDR_W;  `din0_o`  out  DATA_W
- `dout0_i`  in  DATA_W  port-0 read data (muxed by `sel_o` externally)
- `csb1_o`, `web1_o`, `wmask1_o`, `addr1_o`, `din1_o`, `dout1_i`: same for port 1

## Operation
- Chain length L = BURST_W + SEL_W + 2·(ADDR_W + DATA_W + 2 + MASK_W); defaults give 116.
- Fields, MSB→LSB: burst, sel, addr0, din0, csb0, web0, wmask0, addr1, din1, csb1, web1, wmask1.
- Shift: when `scan_en_i`=1 and IDLE, chain <= {chain[L-2:0], scan_in_i}. Shifting is blocked while busy.
- Launch: a rising edge of `launch_i` (registered previous value) while IDLE and `scan_en_i`=0 starts a sequence. The din fields are latched as expected data, and `err_o` is cleared.
- FSM: IDLE → ISSUE (1 cycle) → WAIT (READ_LAT cycles) → CAPTURE (1 cycle) → ISSUE if burst≠0, otherwise DONE (1 cycle, `done_o`=1) → IDLE.
- ISSUE: `csbN_o` = chain csbN field; all other cycles `csbN_o`=1. `webN_o`, `wmaskN_o`, `addrN_o`, `dinN_o` and `sel_o` are registered copies of their chain fields.
- CAPTURE: for each port with csb=0 and web=1, `doutN_i` is written into the dinN chain field.
- Burst step in CAPTURE: the addr fields of active ports increment modulo 2^ADDR_W (0xFFFF→0x0000), and the burst field decrements. Writes always drive the latched expected data, so a burst fills consecutive addresses with one pattern.
- Port with csb field = 1: never selected, and its fields are unchanged.
- `launch_i` edge while busy: ignored, not queued.
- Reset mid-sequence: next cycle → IDLE, `csbN_o`=1, chain cleared.

## Timing
- Reset values: chain 0, `scan_out_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0, `csb0_o`=`csb1_o`=1, `web*_o`=1, all other outputs 0.
- Edge sampled at cycle n → ISSUE at n+1. Each beat takes READ_LAT+2 cycles. `done_o` asserts (burst+1)·(READ_LAT+2) cycles after ISSUE start.
- `busy_o` is high from ISSUE through DONE inclusive.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `SCAN_CMP_EN` defined: in each CAPTURE, every read port compares `doutN_i` against the latched expected data. Any mismatch sets `err_o`, which stays high until the next launch or reset.
- `SCAN_CMP_EN` undefined: compare logic and expected-data latch are removed, and `err_o` is tied 0.

## Test plan
- Reset: assert `wb_rst_i` 2 cycles → `csb0_o`=`csb1_o`=1, `busy_o`=0, `done_o`=0, `err_o`=0, `scan_out_o`=0.
- Single write: scan burst=0, sel=3, addr0=1, din0=0x1, csb0=0, web0=0, wmask0=0xF, csb1=1, then launch → exactly one cycle with `csb0_o`=0, `addr0_o`=1, `din0_o`=1, `sel_o`=3. `csb1_o` stays 1, and `done_o` pulses 3 cycles after ISSUE.
- Dual read: port0 reads addr 1, port1 reads addr 2, model returns 0x1/0x2 → after `done_o`, shifting out 116 bits yields din0=0x00000001 and din1=0x00000002.
- Burst wrap: burst=3, write addr0=0xFFFE, din0=0xA5A5A5A5 → four `csb0_o` pulses 3 cycles apart at 0xFFFE, 0xFFFF, 0x0000, 0x0001, all with data 0xA5A5A5A5. `busy_o` stays high for 13 cycles.
- Compare (`SCAN_CMP_EN`): burst=3 read with expected 0xA5A5A5A5, model corrupts beat 2 → `err_o` rises in that CAPTURE and holds until the next launch. Without the macro, `err_o`=0.
- Robustness: launch edge while busy → ignored. `scan_en_i`=1 while busy → chain unchanged. `wb_rst_i` mid-burst → next cycle `csb0_o`=1, `busy_o`=0, no `done_o`.

Source files
------------

// File: rtl/sram_scan_ctrl.sv
// Scan-chain SRAM test controller: serial chain load, launch/capture FSM, burst stepping.
// Optional read-data compare is built when SCAN_CMP_EN is defined; otherwise err_o is tied low.
//
// state   | meaning
// IDLE    | chain shiftable, waiting for a launch edge
// ISSUE   | chip selects asserted for one cycle
// WAIT    | read latency down-count
// CAPTURE | read data folded into chain, burst step
// DONE    | one-cycle completion pulse
module sram_scan_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MASK_W   = 4,
  parameter int SEL_W    = 4,
  parameter int BURST_W  = 4,
  parameter int READ_LAT = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              scan_en_i,
  input  logic              scan_in_i,
  output logic              scan_out_o,
  input  logic              launch_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              csb0_o,
  output logic              web0_o,
  output logic [MASK_W-1:0] wmask0_o,
  output logic [ADDR_W-1:0] addr0_o,
  output logic [DATA_W-1:0] din0_o,
  input  logic [DATA_W-1:0] dout0_i,
  output logic              csb1_o,
  output logic              web1_o,
  output logic [MASK_W-1:0] wmask1_o,
  output logic [ADDR_W-1:0] addr1_o,
  output logic [DATA_W-1:0] din1_o,
  input  logic [DATA_W-1:0] dout1_i
);

  localparam int PW  = ADDR_W + DATA_W + 2 + MASK_W;
  localparam int L   = BURST_W + SEL_W + 2 * PW;
  localparam int P1  = 0;
  localparam int P0  = PW;
  localparam int WM  = 0;
  localparam int WE  = MASK_W;
  localparam int CS  = MASK_W + 1;
  localparam int DI  = MASK_W + 2;
  localparam int AD  = MASK_W + 2 + DATA_W;
  localparam int SL  = 2 * PW;
  localparam int BUR = 2 * PW + SEL_W;
  localparam int WCW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [WCW-1:0] CNT_LOAD = WCW'((READ_LAT > 0) ? READ_LAT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [L-1:0]   chain_q, chain_d;
  logic [WCW-1:0] cnt_q, cnt_d;
  logic           launch_q;
  logic           launch_go;
  logic           rd0, rd1;

  assign launch_go  = (state_q == S_IDLE) && !scan_en_i && launch_i && !launch_q;
  assign rd0        = !chain_q[P0+CS] && chain_q[P0+WE];
  assign rd1        = !chain_q[P1+CS] && chain_q[P1+WE];
  assign scan_out_o = chain_q[L-1];

  always_comb begin
    state_d = state_q;
    chain_d = chain_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (scan_en_i) chain_d = {chain_q[L-2:0], scan_in_i};
        else if (launch_go) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (READ_LAT == 0) begin
          state_d = S_CAPTURE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_CAPTURE;
        else cnt_d = cnt_q - 1'b1;
      end
      S_CAPTURE: begin
        if (rd0) chain_d[P0+DI +: DATA_W] = dout0_i;
        if (rd1) chain_d[P1+DI +: DATA_W] = dout1_i;
        // inactive ports keep their fields; only selected ports walk forward
        if (chain_q[BUR +: BURST_W] != '0) begin
          chain_d[BUR +: BURST_W] = chain_q[BUR +: BURST_W] - 1'b1;
          if (!chain_q[P0+CS]) chain_d[P0+AD +: ADDR_W] = chain_q[P0+AD +: ADDR_W] + 1'b1;
          if (!chain_q[P1+CS]) chain_d[P1+AD +: ADDR_W] = chain_q[P1+AD +: ADDR_W] + 1'b1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      chain_q  <= '0;
      cnt_q    <= '0;
      launch_q <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      sel_o    <= '0;
      csb0_o   <= 1'b1;
      web0_o   <= 1'b1;
      wmask0_o <= '0;
      addr0_o  <= '0;
      din0_o   <= '0;
      csb1_o   <= 1'b1;
      web1_o   <= 1'b1;
      wmask1_o <= '0;
      addr1_o  <= '0;
      din1_o   <= '0;
    end else begin
      state_q  <= state_d;
      chain_q  <= chain_d;
      cnt_q    <= cnt_d;
      launch_q <= launch_i;
      busy_o   <= (state_d != S_IDLE);
      done_o   <= (state_d == S_DONE);
      csb0_o   <= 1'b1;
      csb1_o   <= 1'b1;
      // port outputs are loaded from the post-step chain so burst beats see the new address
      if (state_d == S_ISSUE) begin
        sel_o    <= chain_d[SL +: SEL_W];
        csb0_o   <= chain_d[P0+CS];
        web0_o   <= chain_d[P0+WE];
        wmask0_o <= chain_d[P0+WM +: MASK_W];
        addr0_o  <= chain_d[P0+AD +: ADDR_W];
        din0_o   <= chain_d[P0+DI +: DATA_W];
        csb1_o   <= chain_d[P1+CS];
        web1_o   <= chain_d[P1+WE];
        wmask1_o <= chain_d[P1+WM +: MASK_W];
        addr1_o  <= chain_d[P1+AD +: ADDR_W];
        din1_o   <= chain_d[P1+DI +: DATA_W];
      end
    end
  end

`ifdef SCAN_CMP_EN
  logic [DATA_W-1:0] exp0_q, exp1_q;
  logic              err_q;
  logic              mismatch;

  assign mismatch = (state_q == S_CAPTURE) &&
                    ((rd0 && (dout0_i != exp0_q)) || (rd1 && (dout1_i != exp1_q)));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      exp0_q <= '0;
      exp1_q <= '0;
      err_q  <= 1'b0;
    end else if (launch_go) begin
      exp0_q <= chain_q[P0+DI +: DATA_W];
      exp1_q <= chain_q[P1+DI +: DATA_W];
      err_q  <= 1'b0;
    end else if (mismatch) begin
      err_q  <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
